// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array blocks (feeder, PE, array, collector).
package systolic_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StDrain  = 2'd2
    } feeder_state_e;

    // Zero vectors needed to push the last real element out of the far corner PE.
    function automatic int unsigned DRAIN_LEN(input int unsigned rows, input int unsigned cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/systolic_vec_fifo.sv
// Synchronous vector FIFO with full/empty flags and a look-ahead full flag for registered ready.
module systolic_vec_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             full_next
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    assign full      = (count_q == FullCnt);
    assign empty     = (count_q == '0);
    assign full_next = (count_d == FullCnt);
    assign rdata     = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset: only slots between rd and wr pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Activation feeder: buffers input vectors, skews them diagonally across the array rows and
// flushes the array with zero vectors before signalling completion.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] in_data,
    input  logic                       in_last,
    input  logic                       array_stall,
    output logic [ROWS*DATA_WIDTH-1:0] out_data,
    output logic [ROWS-1:0]            out_valid,
    output logic                       bubble,
    output logic                       done,
    output logic                       busy
);
    localparam int unsigned VecW     = ROWS * DATA_WIDTH;
    localparam int unsigned DrainLen = DRAIN_LEN(ROWS, COLS);
    localparam int unsigned CntW     = $clog2(DrainLen + 1);

    feeder_state_e   state_q;
    logic [CntW-1:0] drain_cnt_q;
    logic            in_ready_q;
    logic            done_q;

    logic            advance;
    logic            push;
    logic            pop;
    logic            pop_last;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_full_next;
    logic [VecW:0]   fifo_rdata;
    logic            head_last;
    logic [VecW-1:0] head_data;
    logic [VecW-1:0] cur_data;
    logic            cur_valid;

    assign advance  = ~array_stall;
    assign push     = in_valid & in_ready_q & ~fifo_full;
    assign pop      = advance & (state_q == StStream) & ~fifo_empty;
    assign {head_last, head_data} = fifo_rdata;
    assign pop_last = pop & head_last;

    // Vector entering the skew line this cycle; zeros cover both bubbles and flush.
    assign cur_data  = pop ? head_data : '0;
    assign cur_valid = pop;

    systolic_vec_fifo #(
        .WIDTH(VecW + 1),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .wdata    ({in_last, in_data}),
        .pop      (pop),
        .rdata    (fifo_rdata),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .full_next(fifo_full_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            drain_cnt_q <= '0;
            in_ready_q  <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    in_ready_q <= ~fifo_full_next;
                    // Leftovers accepted alongside the previous last vector also start a run.
                    if (push || !fifo_empty) begin
                        state_q <= StStream;
                    end
                end
                StStream: begin
                    if (pop_last) begin
                        state_q     <= StDrain;
                        drain_cnt_q <= CntW'(DrainLen);
                        in_ready_q  <= 1'b0;
                    end else begin
                        in_ready_q <= ~fifo_full_next;
                    end
                end
                StDrain: begin
                    in_ready_q <= 1'b0;
                    if (drain_cnt_q == '0) begin
                        state_q    <= StIdle;
                        in_ready_q <= ~fifo_full_next;
                    end else if (advance) begin
                        drain_cnt_q <= drain_cnt_q - CntW'(1);
                        done_q      <= (drain_cnt_q == CntW'(1));
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign done     = done_q;
    assign busy     = (state_q != StIdle);
    assign bubble   = (state_q == StStream) & fifo_empty;

    // Row 0 has no delay register; the hold keeps it steady while the array is frozen.
    logic [DATA_WIDTH-1:0] row0_hold_q;
    logic                  row0_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row0_hold_q <= '0;
            row0_vld_q  <= 1'b0;
        end else if (advance) begin
            row0_hold_q <= cur_data[DATA_WIDTH-1:0];
            row0_vld_q  <= cur_valid;
        end
    end

    assign out_data[DATA_WIDTH-1:0] = advance ? cur_data[DATA_WIDTH-1:0] : row0_hold_q;
    assign out_valid[0]             = advance ? cur_valid : row0_vld_q;

    for (genvar r = 1; r < ROWS; r++) begin : g_skew
        logic [DATA_WIDTH:0] pipe_q [r];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < r; i++) begin
                    pipe_q[i] <= '0;
                end
            end else if (advance) begin
                pipe_q[0] <= {cur_valid, cur_data[r*DATA_WIDTH +: DATA_WIDTH]};
                for (int i = 1; i < r; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign out_data[r*DATA_WIDTH +: DATA_WIDTH] = pipe_q[r-1][DATA_WIDTH-1:0];
        assign out_valid[r]                          = pipe_q[r-1][DATA_WIDTH];
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: skew, back-pressure, bubbles, drain, stalls and reset.
module tb_systolic_feeder;
    localparam int DW = 8;
    localparam int NR = 4;
    localparam int NC = 4;
    localparam int ND = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              array_stall = 1'b0;
    logic [NR*DW-1:0]  in_data = '0;
    logic              in_ready;
    logic [NR*DW-1:0]  out_data;
    logic [NR-1:0]     out_valid;
    logic              bubble;
    logic              done;
    logic              busy;

    int checks = 0;
    int errors = 0;

    // Vector seen on row 0 at each advance index (index = cycle offset in a scenario).
    logic [31:0] pv [64];
    logic        pvl [64];

    always #5 clk = ~clk;

    systolic_feeder #(
        .DATA_WIDTH(DW),
        .ROWS      (NR),
        .COLS      (NC),
        .DEPTH     (ND)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .array_stall(array_stall),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .bubble     (bubble),
        .done       (done),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #3;
    endtask

    function automatic logic [31:0] vec(input int base, input int i);
        logic [31:0] v;
        v = '0;
        for (int r = 0; r < 4; r++) v[r*8 +: 8] = 8'(base + 16 * i + r);
        return v;
    endfunction

    task automatic clear_pv();
        for (int i = 0; i < 64; i++) begin
            pv[i]  = '0;
            pvl[i] = 1'b0;
        end
    endtask

    function automatic logic [31:0] exp_data(input int a);
        logic [31:0] w;
        w = '0;
        for (int r = 0; r < 4; r++)
            if (a - r >= 0 && a - r < 64) w[r*8 +: 8] = pv[a-r][r*8 +: 8];
        return w;
    endfunction

    function automatic logic [31:0] exp_valid(input int a);
        logic [31:0] w;
        w = '0;
        for (int r = 0; r < 4; r++)
            if (a - r >= 0 && a - r < 64) w[r] = pvl[a-r];
        return w;
    endfunction

    task automatic check_rows(input string tag, input int a);
        check($sformatf("%s_data_a%0d", tag, a), 32'(out_data), exp_data(a));
        check($sformatf("%s_valid_a%0d", tag, a), 32'(out_valid), exp_valid(a));
    endtask

    // Counts cycles until done; -1 when the bound expires.
    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            in_valid = 1'b0;
            in_last  = 1'b0;
            look();
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({tag, "_done_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    // One last-tagged vector, optional stall window (cycles st_lo..st_hi after accept).
    task automatic run_single(input string tag, input logic [31:0] v, input int st_lo,
                              input int st_hi, input int done_k);
        clear_pv();
        pv[1]  = v;
        pvl[1] = 1'b1;
        step();
        in_valid    = 1'b1;
        in_data     = v;
        in_last     = 1'b1;
        array_stall = 1'b0;
        look();
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        for (int k = 1; k <= done_k + 1; k++) begin
            step();
            in_valid    = 1'b0;
            in_last     = 1'b0;
            in_data     = '0;
            array_stall = (k >= st_lo && k <= st_hi);
            look();
            if (k < st_lo) check_rows(tag, k);
            check($sformatf("%s_done_k%0d", tag, k), 32'(done), 32'(k == done_k));
            check($sformatf("%s_busy_k%0d", tag, k), 32'(busy), 32'(k <= done_k));
        end
        check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
        array_stall = 1'b0;
    endtask

    initial begin
        clear_pv();

        // Reset values
        #12;
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_bubble", 32'(bubble), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_ready", 32'(in_ready), 32'd1);

        // 1: single vector, 7 flush cycles, done at n+9
        run_single("s1", 32'h04030201, 100, 100, 9);

        // 2: six back-to-back vectors
        clear_pv();
        for (int i = 0; i < 6; i++) begin
            pv[i+1]  = vec(16, i);
            pvl[i+1] = 1'b1;
        end
        step();
        in_valid = 1'b1;
        in_data  = vec(16, 0);
        in_last  = 1'b0;
        look();
        check("s2_ready0", 32'(in_ready), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            step();
            in_data = vec(16, i);
            in_last = (i == 5);
            look();
            check($sformatf("s2_ready%0d", i), 32'(in_ready), 32'd1);
            check($sformatf("s2_bubble%0d", i), 32'(bubble), 32'd0);
            check_rows("s2", i);
        end
        for (int k = 6; k <= 9; k++) begin
            step();
            in_valid = 1'b0;
            in_last  = 1'b0;
            look();
            check($sformatf("s2_bubble%0d", k), 32'(bubble), 32'd0);
            check_rows("s2", k);
        end
        wait_done("s2", 5);

        // 3: stall for 8 cycles while the producer keeps pushing
        clear_pv();
        for (int i = 0; i < 6; i++) begin
            pv[i]  = vec(64, i);
            pvl[i] = 1'b1;
        end
        step();
        in_valid = 1'b1;
        in_data  = vec(64, 0);
        in_last  = 1'b0;
        look();
        check("s3_ready_c0", 32'(in_ready), 32'd1);
        step();
        in_data = vec(64, 1);
        look();
        check("s3_ready_c1", 32'(in_ready), 32'd1);
        check("s3_data_c1", 32'(out_data), 32'h00000040);
        for (int c = 2; c <= 9; c++) begin
            step();
            array_stall = 1'b1;
            in_data     = (c <= 4) ? vec(64, c) : vec(64, 5);
            in_last     = (c > 4);
            look();
            check($sformatf("s3_ready_c%0d", c), 32'(in_ready), 32'(c <= 4));
            check($sformatf("s3_hold_c%0d", c), 32'(out_data), 32'h00004140);
            check($sformatf("s3_hold_v_c%0d", c), 32'(out_valid), 32'h3);
        end
        step();
        array_stall = 1'b0;
        look();
        check("s3_ready_c10", 32'(in_ready), 32'd0);
        check_rows("s3", 1);
        step();
        look();
        check("s3_ready_c11", 32'(in_ready), 32'd1);
        check_rows("s3", 2);
        for (int a = 3; a <= 8; a++) begin
            step();
            in_valid = 1'b0;
            in_last  = 1'b0;
            look();
            check_rows("s3", a);
        end
        wait_done("s3", 5);

        // 4: producer gaps of two cycles
        clear_pv();
        pv[1] = vec(32, 0);
        pv[4] = vec(32, 1);
        pv[7] = vec(32, 2);
        pvl[1] = 1'b1;
        pvl[4] = 1'b1;
        pvl[7] = 1'b1;
        step();
        in_valid = 1'b1;
        in_data  = vec(32, 0);
        in_last  = 1'b0;
        look();
        for (int c = 1; c <= 10; c++) begin
            step();
            in_valid = (c == 3 || c == 6);
            in_data  = (c == 3) ? vec(32, 1) : ((c == 6) ? vec(32, 2) : 32'd0);
            in_last  = (c == 6);
            look();
            check($sformatf("s4_bubble%0d", c), 32'(bubble),
                  32'(c == 2 || c == 3 || c == 5 || c == 6));
            check_rows("s4", c);
        end
        wait_done("s4", 5);

        // 5: three stall cycles inside the drain push done from n+9 to n+12
        run_single("s5", 32'h08070605, 4, 6, 12);

        // 6: asynchronous reset with three vectors queued
        step();
        in_valid = 1'b1;
        in_data  = vec(96, 0);
        in_last  = 1'b0;
        look();
        step();
        in_data = vec(96, 1);
        look();
        step();
        array_stall = 1'b1;
        in_data     = vec(96, 2);
        look();
        step();
        in_data = vec(96, 3);
        look();
        step();
        in_valid = 1'b0;
        look();
        check("s6_pre_busy", 32'(busy), 32'd1);
        check("s6_pre_data", 32'(out_data), 32'h00006160);
        #1;
        rst_n = 1'b0;
        #1;
        check("s6_rst_data", 32'(out_data), 32'd0);
        check("s6_rst_valid", 32'(out_valid), 32'd0);
        check("s6_rst_bubble", 32'(bubble), 32'd0);
        check("s6_rst_done", 32'(done), 32'd0);
        check("s6_rst_busy", 32'(busy), 32'd0);
        array_stall = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        check("s6_ready_rel", 32'(in_ready), 32'd1);
        for (int k = 1; k <= 12; k++) begin
            step();
            look();
            check($sformatf("s6_nodone%0d", k), 32'(done), 32'd0);
        end
        check("s6_idle_busy", 32'(busy), 32'd0);
        run_single("s6f", 32'h0d0c0b0a, 100, 100, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Upstream stage of the weight-stationary systolic array: buffers activation vectors from the producer and drives each array row's `input_data` with the diagonal skew the PEs require, so row r sees vector k r cycles after row 0. It frames a matrix operation (first vector to `in_last`), injects zero vectors to flush partial sums through the array, and then pulses `done`. It stalls in lock-step with the array whenever the PEs are frozen for weight loading.

## Interface
- `DATA_WIDTH`, 8: activation width; matches the PE.
- `ROWS`, 4: array rows, equal to the vector length.
- `COLS`, 4: array columns; sets the flush length.
- `DEPTH`, 4: input FIFO depth in vectors; power of two, ≥2.

- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous reset, active-low
- `in_valid`  in  1  producer has a vector
- `in_ready`  out  1  feeder accepts a vector this cycle
- `in_data`  in  ROWS*DATA_WIDTH  activation vector; element r is in bits [r*DATA_WIDTH +: DATA_WIDTH]
- `in_last`  in  1  final vector of the matrix operation
- `array_stall`  in  1  array frozen; tie to the PE `weight_load`
- `out_data`  out  ROWS*DATA_WIDTH  skewed row r drives PE row r `input_data`
- `out_valid`  out  ROWS  bit r set: row r carries a real (non-bubble, non-flush) element
- `bubble`  out  1  STREAM-state cycle with an empty FIFO
- `done`  out  1  one-cycle pulse when the flush completes
- `busy`  out  1  state is not IDLE

## Operation
- FSM states:
  - IDLE: a handshake moves to STREAM.
  - STREAM: popping the vector tagged last moves to DRAIN.
  - DRAIN: the counter expires, `done` pulses, and the FSM moves to IDLE.
- Handshake: a transfer occurs when `in_valid && in_ready`. `in_ready = !fifo_full && state != DRAIN`. `in_ready` is registered from FIFO occupancy and has no combinational path from the pop.
- FIFO stores `{in_last, in_data}`. Writes are allowed during `array_stall`.
- Advance cycle: `array_stall == 0`. Only advance cycles pop the FIFO, shift the skew line, or decrement the drain counter. On a stall, all of these hold.
- STREAM advance with a non-empty FIFO: pop one vector into skew stage 0, with valid=1.
- STREAM advance with an empty FIFO: insert a zero vector with valid=0 and assert `bubble`. No error is raised, because a zero activation adds 0 to the partial sum.
- Skew line: row r is delayed by r registers, so row 0 has zero extra registers and row ROWS-1 has ROWS-1. `out_valid[r]` travels with its data.
- DRAIN: insert zero vectors (valid=0) for exactly ROWS+COLS-1 advance cycles. `done` then pulses for the single following cycle, which need not be an advance cycle.
- Width rule: data passes through unmodified, with no arithmetic.

## Timing
- Reset values: `out_data` is 0, `out_valid` is 0, `bubble` is 0, `done` is 0, `busy` is 0, `in_ready` is 1 once `rst_n` deasserts. The FIFO is empty, the state is IDLE, and the drain counter is 0.
- Latency: a vector accepted in cycle n with an empty FIFO and no stalls appears on row 0 in cycle n+1 and on row r in cycle n+1+r.
- Throughput: one vector per advance cycle.
- A push and a pop may occur in the same cycle. A vector pushed into an empty FIFO is not popped in that same cycle.
- Full FIFO: `in_ready` is 0. Ready returns in the cycle after a pop.
- `in_last` on the first vector is legal: the operation is one vector followed by the flush.
- `array_stall` asserted in DRAIN extends the drain by the stall length. `done` is delayed accordingly.
- A new operation is accepted starting in the cycle after `done`.
- `rst_n` asserted mid-operation clears everything immediately and asynchronously. Partial operations are discarded and no `done` is generated.

## Structure
- `systolic_pkg` holds the `feeder_state_e` enum (IDLE, STREAM, DRAIN) and a `DRAIN_LEN(rows, cols)` function; the PE and later array blocks share the package.
- Sub-module `systolic_vec_fifo`: synchronous FIFO with full/empty flags, parameterized by width and depth, and reusable for the output collector.
- The skew line and the FSM live in `systolic_feeder`.

## Test plan
Parameters: ROWS=4, COLS=4, DEPTH=4 unless a scenario says otherwise.
1. Single vector {4,3,2,1} (element 0 = 1) with `in_last`, no stall:
   - row 0 shows 1 in cycle n+1, row 3 shows 4 in cycle n+4;
   - 7 flush cycles, then `done` pulses once and `busy` drops.
2. Producer holds `in_valid` for 6 vectors while the feeder has no stalls:
   - `in_ready` never drops;
   - each vector appears on row 0 on consecutive cycles;
   - `out_valid` forms a diagonal;
   - no `bubble`.
3. `array_stall` held high for 8 cycles while the producer pushes:
   - `in_ready` drops after 4 accepts;
   - outputs hold;
   - on release, data resumes in order with none lost or duplicated.
4. Producer gaps of 2 cycles between vectors:
   - `bubble` pulses in the gap cycles;
   - zero rows carry `out_valid=0`;
   - order is preserved.
5. `array_stall` pulsed for 3 cycles during DRAIN: `done` arrives exactly 3 cycles later than in scenario 1.
6. `rst_n` asserted mid-STREAM with 3 vectors queued:
   - all outputs go to 0 asynchronously;
   - `in_ready` is 1 after release;
   - no `done`;
   - a fresh operation runs correctly.
